// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter with burst lock, sharing one
// single-port memory between the read engine (port 0) and write-back engine (port 1).
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [CW-1:0] r_lcnt;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_cap;
    logic          w_keep0;
    logic          w_keep1;

    assign w_acc0  = r_gnt0 & req0;
    assign w_acc1  = r_gnt1 & req1;
    // Counter saturates at the cap, so an idle-period burst still yields on the first competing request
    assign w_cap   = r_lcnt == CW'(MAX_LOCK - 1);
    assign w_keep0 = req0 & lock0 & ~(req1 & w_cap);
    assign w_keep1 = req1 & lock1 & ~(req0 & w_cap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_lcnt    <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_acc0 & ~we0;
            r_rvalid1 <= w_acc1 & ~we1;
            case (r_state)
                IDLE: begin
                    if (req0 & (~req1 | r_last)) begin
                        r_state <= OWN0;
                        r_gnt0  <= 1'b1;
                    end else if (req1) begin
                        r_state <= OWN1;
                        r_gnt1  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (w_keep0) begin
                        r_lcnt <= w_cap ? r_lcnt : r_lcnt + 1'b1;
                    end else begin
                        r_last  <= 1'b0;
                        r_lcnt  <= '0;
                        r_state <= req1 ? OWN1 : IDLE;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= req1;
                    end
                end
                OWN1: begin
                    if (w_keep1) begin
                        r_lcnt <= w_cap ? r_lcnt : r_lcnt + 1'b1;
                    end else begin
                        r_last  <= 1'b1;
                        r_lcnt  <= '0;
                        r_state <= req0 ? OWN0 : IDLE;
                        r_gnt1  <= 1'b0;
                        r_gnt0  <= req0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign busy      = r_state != IDLE;
    assign mem_en    = w_acc0 | w_acc1;
    assign mem_we    = r_gnt1 ? (w_acc1 & we1) : (w_acc0 & we0);
    assign mem_addr  = r_gnt1 ? addr1 : addr0;
    assign mem_wdata = r_gnt1 ? wdata1 : wdata0;
    assign rdata     = (r_rvalid0 | r_rvalid1) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a
// cycle-level ownership/shadow-memory reference model.
module tb_mem_port_arbiter;
    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tq[2];
    logic       tw[2];
    logic       tl[2];
    logic [7:0] ta[2];
    logic [7:0] td[2];
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem_arr [256];
    logic       mem_init = 1'b0;
    logic [7:0] shadow [256];
    int         errs = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .req0(tq[0]), .req1(tq[1]), .we0(tw[0]), .we1(tw[1]),
        .lock0(tl[0]), .lock1(tl[1]), .addr0(ta[0]), .addr1(ta[1]),
        .wdata0(td[0]), .wdata1(td[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port memory, 1-cycle read latency, preset to addr ^ 0xA6
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i) ^ 8'hA6;
            mem_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else mem_rdata <= mem_arr[mem_addr];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        for (int p = 0; p < 2; p++) begin
            tq[p] = 1'b0; tw[p] = 1'b0; tl[p] = 1'b0; ta[p] = 8'h00; td[p] = 8'h00;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++; if (gnt0 !== 1'b0) begin errs++; $display("FAIL rst_gnt0 got=%b exp=0", gnt0); end
        checks++; if (gnt1 !== 1'b0) begin errs++; $display("FAIL rst_gnt1 got=%b exp=0", gnt1); end
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errs++; $display("FAIL rst_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
        checks++; if (rdata !== 8'h00) begin errs++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
        checks++; if (mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        do_reset();
        tq[0] = 1'b1; tw[0] = 1'b0; ta[0] = 8'h05;
        tick();
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL sr_gnt got=%b%b exp=10", gnt0, gnt1); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("FAIL sr_mem_en_we got=%b%b exp=10", mem_en, mem_we); end
        checks++; if (mem_addr !== 8'h05) begin errs++; $display("FAIL sr_mem_addr got=%h exp=05", mem_addr); end
        tick();
        tq[0] = 1'b0;
        checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin errs++; $display("FAIL sr_rvalid got=%b%b exp=10", rvalid0, rvalid1); end
        checks++; if (rdata !== 8'hA3) begin errs++; $display("FAIL sr_rdata got=%h exp=a3", rdata); end
        checks++; if (gnt0 !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL sr_idle got gnt0=%b busy=%b exp=0 0", gnt0, busy); end
        tick();
        checks++; if (rvalid0 !== 1'b0) begin errs++; $display("FAIL sr_rvalid_pulse got=%b exp=0", rvalid0); end
    endtask

    task automatic test_tie;
        do_reset();
        tq[0] = 1'b1; tq[1] = 1'b1;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL tie1_gnt got=%b%b exp=10", gnt0, gnt1); end
        tick();
        tq[0] = 1'b0;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin errs++; $display("FAIL tie_handoff got=%b%b exp=01", gnt0, gnt1); end
        tick();
        tq[1] = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL tie_idle got busy=%b exp=0", busy); end
        tq[0] = 1'b1; tq[1] = 1'b1;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL tie2_gnt got=%b%b exp=10", gnt0, gnt1); end
        tick();
        tq[0] = 1'b0;
        tick();
        tq[1] = 1'b0;
        tick();
    endtask

    task automatic test_lock_burst;
        int  n;
        logic got1;
        do_reset();
        tq[0] = 1'b1; tl[0] = 1'b1; tq[1] = 1'b1;
        n = 0;
        got1 = 1'b0;
        for (int i = 0; i < 12 && !got1; i++) begin
            tick();
            if (gnt1) got1 = 1'b1;
            else if (gnt0) n++;
        end
        checks++; if (got1 !== 1'b1) begin errs++; $display("FAIL lock_release got gnt1_seen=%b exp=1", got1); end
        checks++; if (n != ML) begin errs++; $display("FAIL lock_count got=%0d exp=%0d", n, ML); end
        tq[0] = 1'b0; tl[0] = 1'b0;
        tick();
        tq[1] = 1'b0;
        tick();
    endtask

    task automatic test_lock_idle;
        int n;
        do_reset();
        tq[0] = 1'b1; tl[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt0) n++;
        end
        checks++; if (n != 20) begin errs++; $display("FAIL lock_unbounded got=%0d exp=20", n); end
        tq[1] = 1'b1;
        tick();
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errs++; $display("FAIL lock_late_yield got=%b%b exp=01", gnt0, gnt1); end
        tq[0] = 1'b0; tl[0] = 1'b0;
        tick();
        tq[1] = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        logic saw1;
        do_reset();
        saw1 = 1'b0;
        tq[1] = 1'b1; tw[1] = 1'b1; ta[1] = 8'h10; td[1] = 8'h3C;
        tick();
        saw1 |= rvalid1;
        tq[0] = 1'b1; tw[0] = 1'b0; ta[0] = 8'h10;
        tick();
        saw1 |= rvalid1;
        tq[1] = 1'b0;
        checks++; if (gnt0 !== 1'b1) begin errs++; $display("FAIL wr_handoff got gnt0=%b exp=1", gnt0); end
        tick();
        saw1 |= rvalid1;
        tq[0] = 1'b0;
        checks++; if (rvalid0 !== 1'b1 || rdata !== 8'h3C) begin errs++; $display("FAIL wr_readback got rvalid0=%b rdata=%h exp=1 3c", rvalid0, rdata); end
        tick();
        saw1 |= rvalid1;
        checks++; if (saw1 !== 1'b0) begin errs++; $display("FAIL wr_no_rvalid1 got=%b exp=0", saw1); end
    endtask

    task automatic test_routing;
        do_reset();
        tq[0] = 1'b1; ta[0] = 8'h05; tq[1] = 1'b1; ta[1] = 8'h06;
        tick();
        tick();
        tq[0] = 1'b0;
        checks++; if (gnt1 !== 1'b1) begin errs++; $display("FAIL rt_gnt1 got=%b exp=1", gnt1); end
        checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 8'hA3) begin errs++; $display("FAIL rt_port0 got rv=%b%b rdata=%h exp=10 a3", rvalid0, rvalid1, rdata); end
        tick();
        tq[1] = 1'b0;
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata !== 8'hA0) begin errs++; $display("FAIL rt_port1 got rv=%b%b rdata=%h exp=01 a0", rvalid0, rvalid1, rdata); end
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        tq[0] = 1'b1; tl[0] = 1'b1; ta[0] = 8'h22;
        repeat (3) tick();
        checks++; if (gnt0 !== 1'b1 || rvalid0 !== 1'b1) begin errs++; $display("FAIL ar_pre got gnt0=%b rvalid0=%b exp=1 1", gnt0, rvalid0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL ar_gnt_en got gnt=%b%b mem_en=%b exp=00 0", gnt0, gnt1, mem_en); end
        checks++; if (rvalid0 !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00) begin errs++; $display("FAIL ar_state got rvalid0=%b busy=%b rdata=%h exp=0 0 00", rvalid0, busy, rdata); end
        tick();
        #2;
        rst = 1'b0;
        tl[0] = 1'b0;
        tq[1] = 1'b1;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL ar_tie got=%b%b exp=10", gnt0, gnt1); end
        tick();
        tq[0] = 1'b0;
        tick();
        tq[1] = 1'b0;
        tick();
    endtask

    task automatic test_random;
        int         own, last, cnt, o;
        logic       pv0, pv1, acc;
        logic [7:0] pd;
        logic       served[2];
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hA6;
        own = -1; last = 1; cnt = 0; pv0 = 1'b0; pv1 = 1'b0; pd = 8'h00;
        served[0] = 1'b1; served[1] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            checks++; if (gnt0 !== (own == 0) || gnt1 !== (own == 1)) begin errs++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp_owner=%0d", c, gnt0, gnt1, own); end
            checks++; if (busy !== (own >= 0)) begin errs++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, own >= 0); end
            checks++; if (rvalid0 !== pv0 || rvalid1 !== pv1) begin errs++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", c, rvalid0, rvalid1, pv0, pv1); end
            if (pv0 || pv1) begin
                checks++; if (rdata !== pd) begin errs++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rdata, pd); end
            end
            for (int p = 0; p < 2; p++) begin
                if (!tq[p] || served[p]) begin
                    tq[p] = $urandom_range(0, 2) != 0;
                    tw[p] = $urandom_range(0, 1) != 0;
                    ta[p] = 8'h80 | 8'($urandom_range(0, 127));
                    td[p] = 8'($urandom_range(0, 255));
                end
                tl[p] = $urandom_range(0, 3) != 0;
            end
            #1;
            o = (own < 0) ? 0 : own;
            acc = (own >= 0) && tq[o];
            checks++; if (mem_en !== acc) begin errs++; $display("FAIL rnd_mem_en cyc=%0d got=%b exp=%b", c, mem_en, acc); end
            if (acc) begin
                checks++; if (mem_we !== tw[o] || mem_addr !== ta[o]) begin errs++; $display("FAIL rnd_mem_cmd cyc=%0d got we=%b addr=%h exp we=%b addr=%h", c, mem_we, mem_addr, tw[o], ta[o]); end
                if (tw[o]) begin
                    checks++; if (mem_wdata !== td[o]) begin errs++; $display("FAIL rnd_mem_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, td[o]); end
                end
            end
            served[0] = 1'b0; served[1] = 1'b0;
            pv0 = 1'b0; pv1 = 1'b0;
            if (acc) begin
                served[o] = 1'b1;
                if (tw[o]) shadow[ta[o]] = td[o];
                else begin
                    pd = shadow[ta[o]];
                    if (o == 0) pv0 = 1'b1; else pv1 = 1'b1;
                end
            end
            if (own < 0) begin
                if (tq[0] && tq[1]) own = 1 - last;
                else if (tq[0]) own = 0;
                else if (tq[1]) own = 1;
            end else if (tq[o] && tl[o] && !(tq[1-o] && cnt >= ML - 1)) begin
                cnt++;
            end else begin
                last = o;
                cnt = 0;
                own = tq[1-o] ? 1 - o : -1;
            end
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        clear_inputs();
        tick();
        test_reset();
        test_single_read();
        test_tie();
        test_lock_burst();
        test_lock_idle();
        test_write_read();
        test_routing();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
